// File: rtl/mod4051_residue_accumulator.sv
// Modulo-MOD accumulator for chunk-LUT partial residues.
// Collects one operand's terms and presents the residue, count and length error.
module mod4051_residue_accumulator #(
    parameter int MOD       = 4051,
    parameter int NUM_TERMS = 84,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [11:0]      s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [11:0]      m_data,
    output logic [CNT_W-1:0] m_count,
    output logic             m_err
);

    typedef enum logic {ACC, DONE} state_t;

    localparam logic [11:0]      MOD12 = 12'(MOD);
    localparam logic [12:0]      MOD13 = 13'(MOD);
    localparam logic [CNT_W-1:0] NTC   = CNT_W'(NUM_TERMS);

    state_t           state, state_n;
    logic [11:0]      acc, acc_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             m_valid_d;
    logic [11:0]      m_data_d;
    logic [CNT_W-1:0] m_count_d;
    logic             m_err_d;

    logic [11:0]      d;
    logic [12:0]      t;
    logic [12:0]      t_sub;
    logic [11:0]      acc_n;
    logic [CNT_W-1:0] cnt_n;
    logic             last_beat;

    assign s_ready = (state == ACC);

    always_comb begin
        d         = (s_data >= MOD12) ? (s_data - MOD12) : s_data;
        t         = {1'b0, acc} + {1'b0, d};
        t_sub     = t - MOD13;
        acc_n     = (t >= MOD13) ? t_sub[11:0] : t[11:0];
        cnt_n     = cnt + 1'b1;
        last_beat = s_last | (cnt_n == NTC);

        state_n   = state;
        acc_d     = acc;
        cnt_d     = cnt;
        m_valid_d = m_valid;
        m_data_d  = m_data;
        m_count_d = m_count;
        m_err_d   = m_err;

        unique case (state)
            ACC: begin
                if (s_valid) begin
                    if (last_beat) begin
                        m_data_d  = acc_n;
                        m_count_d = cnt_n;
                        m_err_d   = (cnt_n != NTC) | ~s_last;
                        m_valid_d = 1'b1;
                        acc_d     = '0;
                        cnt_d     = '0;
                        state_n   = DONE;
                    end else begin
                        acc_d = acc_n;
                        cnt_d = cnt_n;
                    end
                end
            end
            DONE: begin
                // Result holds until taken; input stays stalled meanwhile.
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_n   = ACC;
                end
            end
            default: state_n = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACC;
            acc     <= '0;
            cnt     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_count <= '0;
            m_err   <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_d;
            cnt     <= cnt_d;
            m_valid <= m_valid_d;
            m_data  <= m_data_d;
            m_count <= m_count_d;
            m_err   <= m_err_d;
        end
    end

endmodule

// File: tb/tb_mod4051_residue_accumulator.sv
// Self-checking bench for mod4051_residue_accumulator.
// Expected residues come from plain modular arithmetic over each operand.
module tb_mod4051_residue_accumulator;

    localparam int MOD = 4051;
    localparam int NT  = 84;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [11:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [11:0] m_data;
    logic [6:0]  m_count;
    logic        m_err;

    int errors = 0;
    int checks = 0;
    int q[$];

    always #5 clk = ~clk;

    mod4051_residue_accumulator #(
        .MOD(MOD), .NUM_TERMS(NT), .CNT_W(7)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_count(m_count), .m_err(m_err)
    );

    task automatic send(input int v, input bit last);
        int n = 0;
        s_valid = 1'b1;
        s_data  = 12'(v);
        s_last  = last;
        while (!s_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout s_ready=%0b required 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Send q as one operand and check the result one cycle after the final accept.
    task automatic run_op(input bit with_last, input string name);
        int n = q.size();
        int sum = 0;
        int exp_cnt = (n > NT) ? NT : n;
        bit exp_err;
        for (int i = 0; i < exp_cnt; i++) sum = (sum + q[i]) % MOD;
        exp_err = (exp_cnt != NT) || !(with_last && exp_cnt == n);
        for (int i = 0; i < exp_cnt; i++) begin
            if (i == exp_cnt - 1) begin
                checks++;
                if (m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_valid got=%0b required 0", name, m_valid);
                end
            end
            send(q[i], with_last && (i == n - 1));
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 12'(sum) ||
            m_count !== 7'(exp_cnt) || m_err !== exp_err) begin
            errors++;
            $display("FAIL %s result got v=%0b d=%0d c=%0d e=%0b required v=1 d=%0d c=%0d e=%0b",
                     name, m_valid, m_data, m_count, m_err, sum, exp_cnt, exp_err);
        end
    endtask

    task automatic consume(input string name);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s consume got v=%0b r=%0b required v=0 r=1",
                     name, m_valid, s_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({s_ready, m_valid, m_data, m_count, m_err} !== {1'b1, 1'b0, 12'd0, 7'd0, 1'b0}) begin
            errors++;
            $display("FAIL %s got r=%0b v=%0b d=%0d c=%0d e=%0b required r=1 v=0 d=0 c=0 e=0",
                     name, s_ready, m_valid, m_data, m_count, m_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("after_release");
    endtask

    task automatic test_directed();
        q = {};
        repeat (NT) q.push_back(1);
        run_op(1'b1, "ones"); consume("ones");
        q = {4050, 1};
        repeat (82) q.push_back(0);
        run_op(1'b1, "wrap_zero"); consume("wrap_zero");
        q = {4050, 4050};
        repeat (82) q.push_back(0);
        run_op(1'b1, "wrap_4049"); consume("wrap_4049");
        q = {4095};
        run_op(1'b1, "single_4095"); consume("single_4095");
        q = {4051};
        run_op(1'b1, "single_4051"); consume("single_4051");
    endtask

    task automatic test_forced_end();
        q = {};
        repeat (NT + 1) q.push_back(100);
        run_op(1'b0, "forced"); consume("forced");
        q = {5};
        run_op(1'b1, "beat85"); consume("beat85");
    endtask

    task automatic test_backpressure();
        logic [11:0] held;
        q = {7, 8};
        run_op(1'b1, "bp_first");
        held = m_data;
        s_valid = 1'b1;
        s_data  = 12'd123;
        s_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== held) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got r=%0b v=%0b d=%0d required r=0 v=1 d=%0d",
                         i, s_ready, m_valid, m_data, held);
            end
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got r=%0b v=%0b required r=1 v=0", s_ready, m_valid);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 12'd123 || m_count !== 7'd1 || m_err !== 1'b1) begin
            errors++;
            $display("FAIL bp_held_term got v=%0b d=%0d c=%0d e=%0b required v=1 d=123 c=1 e=1",
                     m_valid, m_data, m_count, m_err);
        end
        consume("bp_held_term");
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 40; i++) send(3000, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        q = {};
        repeat (NT) q.push_back(2);
        run_op(1'b1, "post_reset"); consume("post_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            int len = $urandom_range(1, NT);
            bit wl = (len < NT) ? 1'b1 : 1'($urandom_range(0, 1));
            q = {};
            for (int i = 0; i < len; i++) q.push_back(int'($urandom_range(0, 4095)));
            run_op(wl, $sformatf("rand%0d", k));
            consume($sformatf("rand%0d", k));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_forced_end();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
